// File: rtl/rate_pkg.sv
// Shared definitions for the rate enable generator.
// Holds the Speed encodings and the period lookup used by the RTL and the bench.
package rate_pkg;

  localparam logic [1:0] SPEED_FULL = 2'b00;
  localparam logic [1:0] SPEED_1X   = 2'b01;
  localparam logic [1:0] SPEED_2X   = 2'b10;
  localparam logic [1:0] SPEED_4X   = 2'b11;

  // Strobe period in clock cycles for a given rate select.
  // Computed at 64 bits so that 4*F cannot overflow for any realistic clock.
  function automatic longint unsigned period_cycles(input logic [1:0]       speed,
                                                    input longint unsigned  clock_frequency);
    case (speed)
      SPEED_FULL: return 64'd1;
      SPEED_1X:   return clock_frequency;
      SPEED_2X:   return 64'd2 * clock_frequency;
      default:    return 64'd4 * clock_frequency;
    endcase
  endfunction

endpackage

// File: rtl/rate_reload_sel.sv
// Combinational reload selector: maps a rate select to the down-counter
// reload value (period - 1).
// Ports:
//   speed  [1:0]             rate select
//   reload [COUNT_WIDTH-1:0] period(speed) - 1
module rate_reload_sel
  import rate_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 50_000_000,
  parameter int COUNT_WIDTH     = $clog2(4 * CLOCK_FREQUENCY)
) (
  input  logic [1:0]             speed,
  output logic [COUNT_WIDTH-1:0] reload
);

  logic [63:0] period;

  always_comb begin
    period = period_cycles(speed, 64'(CLOCK_FREQUENCY));
    reload = COUNT_WIDTH'(period - 64'd1);
  end

endmodule

// File: rtl/rate_enable_gen.sv
// Programmable rate divider producing a registered single-cycle Enable strobe
// once every 1, F, 2F or 4F clock cycles for the downstream counter stage.
// Ports:
//   Clock    sole clock, rising edge
//   Clear_b  asynchronous active-low clear
//   Run      1 = divider counts, 0 = frozen, no strobes
//   Speed    rate select (00 full, 01 F, 10 2F, 11 4F)
//   Enable   registered single-cycle strobe
module rate_enable_gen
  import rate_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 50_000_000,
  parameter int COUNT_WIDTH     = $clog2(4 * CLOCK_FREQUENCY)
) (
  input  logic       Clock,
  input  logic       Clear_b,
  input  logic       Run,
  input  logic [1:0] Speed,
  output logic       Enable
);

  logic [COUNT_WIDTH-1:0] rate_count_q, rate_count_d;
  logic [1:0]             speed_q, speed_d;
  logic                   enable_q, enable_d;

  logic                   speed_change;
  logic [1:0]             reload_speed;
  logic [COUNT_WIDTH-1:0] reload;

  assign speed_change = (Speed != speed_q);
  // A single selector serves both reload cases: the new Speed on a change,
  // otherwise the accepted speed for terminal-count reloads.
  assign reload_speed = speed_change ? Speed : speed_q;

  rate_reload_sel #(
    .CLOCK_FREQUENCY(CLOCK_FREQUENCY),
    .COUNT_WIDTH    (COUNT_WIDTH)
  ) u_reload_sel (
    .speed (reload_speed),
    .reload(reload)
  );

  always_comb begin
    rate_count_d = rate_count_q;
    speed_d      = speed_q;
    enable_d     = 1'b0;
    if (speed_change) begin
      // Restart the period on any rate change, even while paused.
      speed_d      = Speed;
      rate_count_d = reload;
    end else if (!Run) begin
      rate_count_d = rate_count_q;
    end else if (rate_count_q == '0) begin
      enable_d     = 1'b1;
      rate_count_d = reload;
    end else begin
      rate_count_d = rate_count_q - 1'b1;
    end
  end

  always_ff @(posedge Clock or negedge Clear_b) begin
    if (!Clear_b) begin
      rate_count_q <= '0;
      speed_q      <= SPEED_FULL;
      enable_q     <= 1'b0;
    end else begin
      rate_count_q <= rate_count_d;
      speed_q      <= speed_d;
      enable_q     <= enable_d;
    end
  end

  assign Enable = enable_q;

endmodule

// File: tb/tb_rate_enable_gen.sv
module tb_rate_enable_gen;
  import rate_pkg::*;

  localparam int F  = 4;
  localparam int CW = 4;

  logic       Clock = 1'b0;
  logic       Clear_b;
  logic       Run;
  logic [1:0] Speed;
  logic       Enable;

  int tests_run    = 0;
  int tests_failed = 0;
  logic exp_q[$];

  rate_enable_gen #(.CLOCK_FREQUENCY(F), .COUNT_WIDTH(CW)) dut (
    .Clock  (Clock),
    .Clear_b(Clear_b),
    .Run    (Run),
    .Speed  (Speed),
    .Enable (Enable)
  );

  always #5 Clock = ~Clock;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_bit(input logic obs, input logic exp, input string tag);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_cnt(input logic [CW-1:0] exp, input string tag);
    tests_run++;
    assert (dut.rate_count_q === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, dut.rate_count_q, exp);
    end
  endtask

  // One clock: push the expected strobe at the edge, pop and compare at the
  // following falling edge.
  task automatic cycle(input logic exp_en, input string tag);
    logic e;
    @(posedge Clock);
    exp_q.push_back(exp_en);
    @(negedge Clock);
    tests_run++;
    if (exp_q.size() == 0) begin
      tests_failed++;
      $display("FAIL %s: observed empty scoreboard expected entry", tag);
    end else begin
      e = exp_q.pop_front();
      assert (Enable === e) else begin
        tests_failed++;
        $error("FAIL %s: observed %b expected %b", tag, Enable, e);
      end
    end
  endtask

  function automatic logic strobe_at(input int edge_n, input int p);
    return (edge_n >= p + 1) && (((edge_n - (p + 1)) % p) == 0);
  endfunction

  initial begin
    int p1, p2, p4;
    int strobes;
    p1 = int'(period_cycles(SPEED_1X, 64'(F)));
    p2 = int'(period_cycles(SPEED_2X, 64'(F)));
    p4 = int'(period_cycles(SPEED_4X, 64'(F)));

    // Reset state
    Clear_b = 1'b0; Run = 1'b1; Speed = SPEED_FULL;
    #2;
    check_bit(Enable, 1'b0, "reset_enable");
    check_cnt(4'd0, "reset_count");
    @(negedge Clock);
    Clear_b = 1'b1;

    // Full speed: strobe after every edge
    strobes = 0;
    for (int e = 1; e <= 20; e++) begin
      cycle(1'b1, "full_speed");
      if (Enable === 1'b1) strobes++;
    end
    tests_run++;
    assert (strobes == 20) else begin
      tests_failed++;
      $error("FAIL full_count: observed %0d expected 20", strobes);
    end

    // 1x rate from reset
    Clear_b = 1'b0; Speed = SPEED_1X;
    #1;
    Clear_b = 1'b1;
    for (int e = 1; e <= 18; e++) cycle(strobe_at(e, p1), "rate_1x");

    // Pause with Speed 4X
    Clear_b = 1'b0; Speed = SPEED_4X;
    #1;
    Clear_b = 1'b1;
    for (int e = 1; e <= 6; e++) cycle(1'b0, "pause_pre");
    check_cnt(4'd10, "pause_start_count");
    Run = 1'b0;
    for (int e = 7; e <= 12; e++) begin
      cycle(1'b0, "paused_enable");
      check_cnt(4'd10, "paused_count");
    end
    Run = 1'b1;
    for (int e = 13; e <= p4 + 6; e++) cycle(1'b0, "pause_resume");
    cycle(1'b1, "pause_delayed_strobe");
    check_cnt(4'(p4 - 1), "pause_reload");

    // Speed change mid-count (11 -> 01 at count 9)
    for (int e = 1; e <= 6; e++) cycle(1'b0, "pre_change");
    check_cnt(4'd9, "pre_change_count");
    Speed = SPEED_1X;
    cycle(1'b0, "change_edge");
    check_cnt(4'd3, "change_count");
    for (int e = 1; e <= 12; e++) cycle((e % p1) == 0, "after_change");

    // Speed change coinciding with terminal count (01 -> 10)
    for (int e = 1; e <= 3; e++) cycle(1'b0, "to_terminal");
    check_cnt(4'd0, "terminal_count");
    Speed = SPEED_2X;
    cycle(1'b0, "terminal_change_edge");
    check_cnt(4'(p2 - 1), "terminal_change_count");
    for (int e = 1; e <= p2 - 1; e++) cycle(1'b0, "terminal_wait");
    cycle(1'b1, "terminal_next_strobe");

    // Asynchronous clear while Enable is high, between edges
    check_bit(Enable, 1'b1, "pre_clear_enable");
    #2;
    Clear_b = 1'b0;
    #1;
    check_bit(Enable, 1'b0, "async_clear_enable");
    check_cnt(4'd0, "async_clear_count");
    Speed = SPEED_1X;
    #1;
    Clear_b = 1'b1;
    for (int e = 1; e <= 18; e++) cycle(strobe_at(e, p1), "post_clear_1x");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
